// File: rtl/tracer_reader.sv
`timescale 1ns/1ps
// tracer_reader
//   Wishbone initiator that drives a trace logger. After a start pulse it
//   writes the post-trigger count, arms the trigger, waits a fixed capture
//   window and then reads every word of every trace bank. Each word read is
//   forwarded on a valid/ready stream.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-high reset
//   wbm_*                    Wishbone initiator (single, non-pipelined cycles)
//   start_i                  one-cycle start; trigger_i / post_cnt_i are latched with it
//   busy_o / done_o / err_o  sequence status (err_o sticky until next start)
//   out_data_o/_valid_o/_ready_i/_last_o  trace word stream
//
// Build option
//   TRACER_READER_HEADER_EN  emit 32'hDA7A_0000 | bank before the first word of each bank.
module tracer_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned WAIT_CYCLES = 2048
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        start_i,
  input  logic [31:0] trigger_i,
  input  logic [9:0]  post_cnt_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o
);

  localparam int unsigned WordW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WordW-1:0] WordLast = WordW'(NUM_WORDS - 1);
  localparam logic [1:0]       BankLast = 2'(NUM_BANKS - 1);
  localparam logic [31:0]      WaitLast = 32'(WAIT_CYCLES - 1);
`ifdef TRACER_READER_HEADER_EN
  localparam logic HdrEn = 1'b1;
`else
  localparam logic HdrEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StWrPost, StWrArm, StWait, StRd, StOut, StFin
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      adr_q, adr_d, dat_q, dat_d;
  logic             we_q, we_d, cyc_q, cyc_d, err_q, err_d;
  logic [31:0]      trig_q, trig_d, wait_q, wait_d;
  logic [9:0]       post_q, post_d;
  logic [WordW-1:0] word_q, word_d;
  logic [1:0]       bank_q, bank_d;
  logic             hdr_q, hdr_d;  // next stream item is the bank header
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;

  logic        bus_active, bus_ack, bus_err, is_final;
  logic [31:0] rd_adr, tgt_adr, tgt_dat;
  logic        tgt_we;

  // Ack/err only count while our own cycle is open.
  assign bus_ack    = cyc_q & wbm_ack_i;
  assign bus_err    = cyc_q & wbm_err_i;
  assign is_final   = (bank_q == BankLast) && (word_q == WordLast);
  assign bus_active = (state_q == StWrPost) || (state_q == StWrArm) ||
                      ((state_q == StRd) && !hdr_q);
  assign rd_adr     = BASE_ADDR + {18'b0, bank_q, 12'b0} +
                      {{(30 - WordW){1'b0}}, word_q, 2'b00};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      err_q       <= 1'b0;
      trig_q      <= '0;
      wait_q      <= '0;
      post_q      <= '0;
      word_q      <= '0;
      bank_q      <= '0;
      hdr_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      cyc_q       <= cyc_d;
      err_q       <= err_d;
      trig_q      <= trig_d;
      wait_q      <= wait_d;
      post_q      <= post_d;
      word_q      <= word_d;
      bank_q      <= bank_d;
      hdr_q       <= hdr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StWrPost;
      StWrPost: if (bus_err) state_d = StFin; else if (bus_ack) state_d = StWrArm;
      StWrArm:  if (bus_err) state_d = StFin; else if (bus_ack) state_d = StWait;
      StWait:   if (wait_q == WaitLast) state_d = StRd;
      StRd: begin
        if (hdr_q)        state_d = StOut;
        else if (bus_err) state_d = StFin;
        else if (bus_ack) state_d = StOut;
      end
      StOut:    if (out_ready_i) state_d = (is_final && !hdr_q) ? StFin : StRd;
      StFin:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    cyc_d       = cyc_q;
    err_d       = err_q;
    trig_d      = trig_q;
    wait_d      = wait_q;
    post_d      = post_q;
    word_d      = word_q;
    bank_d      = bank_q;
    hdr_d       = hdr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    tgt_adr     = rd_adr;
    tgt_dat     = '0;
    tgt_we      = 1'b0;

    if (state_q == StWrPost) begin
      tgt_adr = BASE_ADDR + 32'h10;
      tgt_dat = {22'b0, post_q};
      tgt_we  = 1'b1;
    end else if (state_q == StWrArm) begin
      tgt_adr = BASE_ADDR;
      tgt_dat = trig_q;
      tgt_we  = 1'b1;
    end

    // A cycle opens on the first clock in a bus state; since every bus state is
    // entered with cyc low, the bus always idles one clock between transactions.
    if (bus_active) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        adr_d = tgt_adr;
        dat_d = tgt_dat;
        we_d  = tgt_we;
      end else if (wbm_err_i || wbm_ack_i) begin
        cyc_d = 1'b0;
        adr_d = '0;
        dat_d = '0;
        we_d  = 1'b0;
        if (wbm_err_i) begin
          err_d = 1'b1;
        end else if (state_q == StRd) begin
          out_data_d  = wbm_dat_i;
          out_valid_d = 1'b1;
          out_last_d  = is_final;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          trig_d = trigger_i;
          post_d = post_cnt_i;
          err_d  = 1'b0;
        end
      end
      StWrArm: wait_d = '0;
      StWait: begin
        wait_d = wait_q + 32'd1;
        if (wait_q == WaitLast) begin
          word_d = '0;
          bank_d = '0;
          hdr_d  = HdrEn;
        end
      end
      StRd: begin
        if (hdr_q) begin
          out_data_d  = 32'hDA7A_0000 | {30'b0, bank_q};
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
        end
      end
      StOut: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (hdr_q) begin
            hdr_d = 1'b0;
          end else if (word_q == WordLast) begin
            word_d = '0;
            bank_d = bank_q + 2'd1;
            hdr_d  = HdrEn;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != StIdle) && (state_q != StFin);
    done_o      = (state_q == StFin);
    err_o       = err_q;
    wbm_adr_o   = adr_q;
    wbm_dat_o   = dat_q;
    wbm_we_o    = we_q;
    wbm_cyc_o   = cyc_q;
    wbm_stb_o   = cyc_q;
    wbm_sel_o   = 4'hf;
    out_data_o  = out_data_q;
    out_valid_o = out_valid_q;
    out_last_o  = out_last_q;
  end

endmodule

// File: tb/tb_tracer_reader.sv
`timescale 1ns/1ps
module tb_tracer_reader;

  localparam logic [31:0] Base    = 32'h0004_0000;
  localparam int          NWords  = 64;
  localparam int          NBanks  = 4;
  localparam int          WaitCyc = 40;
  localparam int          NReads  = NWords * NBanks;
`ifdef TRACER_READER_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wbm_adr, wbm_dat_o, out_data;
  logic [3:0]  wbm_sel;
  logic        wbm_we, wbm_cyc, wbm_stb, busy, done, err_o, out_valid, out_last;
  logic [31:0] wbm_dat_i  = '0;
  logic        wbm_ack    = 1'b0;
  logic        wbm_err    = 1'b0;
  logic        start      = 1'b0;
  logic [31:0] trigger    = '0;
  logic [9:0]  post_cnt   = '0;
  logic        out_ready  = 1'b0;

  tracer_reader #(
    .BASE_ADDR  (Base),
    .NUM_WORDS  (NWords),
    .NUM_BANKS  (NBanks),
    .WAIT_CYCLES(WaitCyc)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbm_adr_o  (wbm_adr),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel),
    .wbm_we_o   (wbm_we),
    .wbm_cyc_o  (wbm_cyc),
    .wbm_stb_o  (wbm_stb),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack),
    .wbm_err_i  (wbm_err),
    .start_i    (start),
    .trigger_i  (trigger),
    .post_cnt_i (post_cnt),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err_o),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_last_o (out_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic        err;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  txn_t  txn_q[$];
  word_t out_q[$];

  logic [31:0] salt = 32'h0;
  int err_txn     = -1;
  int ready_pct   = 100;
  int stall_word  = -1;
  int stall_left  = 0;
  int cyc_cnt     = 0;
  int arm_ack_cyc = -1;
  int first_rd_cyc = -1;
  int done_cnt    = 0;

  // Slave memory contents: an arbitrary function of address and per-run salt.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt ^ 32'h1234_5678;
  endfunction

  // Wishbone slave, bus monitor and stream sink, all acting on the falling edge.
  bit          resp_q = 1'b0;
  bit          in_cyc = 1'b0;
  int          lat    = 0;
  logic [31:0] prev_adr, prev_dat;
  logic        prev_we;
  bit          held = 1'b0;
  logic [31:0] held_data;

  always @(negedge clk) begin
    cyc_cnt++;
    if (rst) begin
      wbm_ack = 1'b0;
      wbm_err = 1'b0;
      resp_q  = 1'b0;
      in_cyc  = 1'b0;
      held    = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        check("busy_at_done", {31'b0, busy}, 32'd0);
      end
      check("stb_follows_cyc", {31'b0, wbm_stb}, {31'b0, wbm_cyc});
      check("sel", {28'b0, wbm_sel}, 32'hf);
      if (resp_q) begin
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
        resp_q  = 1'b0;
        in_cyc  = 1'b0;
        check("cyc_drop_after_resp", {31'b0, wbm_cyc}, 32'd0);
      end else if (wbm_cyc) begin
        if (!in_cyc) begin
          in_cyc   = 1'b1;
          lat      = $urandom_range(0, 2);
          prev_adr = wbm_adr;
          prev_dat = wbm_dat_o;
          prev_we  = wbm_we;
          if (!wbm_we && first_rd_cyc < 0) first_rd_cyc = cyc_cnt;
        end else begin
          check("bus_adr_stable", wbm_adr, prev_adr);
          check("bus_we_stable", {31'b0, wbm_we}, {31'b0, prev_we});
          if (prev_we) check("bus_dat_stable", wbm_dat_o, prev_dat);
        end
        if (lat == 0) begin
          txn_t t;
          t.adr = wbm_adr;
          t.we  = wbm_we;
          t.dat = wbm_we ? wbm_dat_o : 32'h0;
          t.err = (txn_q.size() == err_txn);
          if (t.err) wbm_err = 1'b1;
          else begin
            wbm_ack = 1'b1;
            wbm_dat_i = wbm_we ? 32'h0 : mem_word(wbm_adr);
            if (wbm_we && wbm_adr == Base) arm_ack_cyc = cyc_cnt;
          end
          txn_q.push_back(t);
          resp_q = 1'b1;
        end else begin
          lat--;
        end
      end

      if (held) begin
        check("out_hold_valid", {31'b0, out_valid}, 32'd1);
        check("out_hold_data", out_data, held_data);
      end
      if (out_valid && out_q.size() == stall_word && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        check("stall_no_bus", {31'b0, wbm_cyc}, 32'd0);
      end else begin
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (out_valid && out_ready) begin
        word_t w;
        w.data = out_data;
        w.last = out_last;
        out_q.push_back(w);
        held = 1'b0;
      end else begin
        held      = out_valid;
        held_data = out_data;
      end
    end
  end

  // One full start-to-done sequence against the reference model.
  task automatic run_seq(input logic [31:0] trig, input logic [9:0] post, input int etx,
                         input int stall_w, input int rdy, input bit poke, input bit exp_err);
    txn_t  exp_t[$];
    word_t exp_w[$];
    int d0;
    int poke_st = 0;
    txn_q.delete();
    out_q.delete();
    first_rd_cyc = -1;
    arm_ack_cyc  = -1;
    err_txn      = etx;
    stall_word   = stall_w;
    stall_left   = (stall_w >= 0) ? 50 : 0;
    ready_pct    = rdy;
    salt         = $urandom;
    d0           = done_cnt;

    // Reference: the ordered list of bus accesses and stream words.
    for (int i = 0; i < 2 + NReads; i++) begin
      txn_t t;
      if (etx >= 0 && i > etx) break;
      if (i == 0) begin
        t.adr = Base + 32'h10; t.dat = {22'b0, post}; t.we = 1'b1;
      end else if (i == 1) begin
        t.adr = Base; t.dat = trig; t.we = 1'b1;
      end else begin
        t.adr = Base + 32'((i - 2) / NWords) * 32'h1000 + 32'((i - 2) % NWords) * 4;
        t.dat = 32'h0; t.we = 1'b0;
      end
      t.err = (i == etx);
      exp_t.push_back(t);
    end
    if (etx < 0 || etx >= 2) begin
      for (int r = 0; r < NReads; r++) begin
        word_t w;
        if (HdrEn && (r % NWords) == 0) begin
          w.data = 32'hDA7A_0000 + 32'(r / NWords);
          w.last = 1'b0;
          exp_w.push_back(w);
        end
        if (etx == r + 2) break;
        w.data = mem_word(Base + 32'(r / NWords) * 32'h1000 + 32'(r % NWords) * 4);
        w.last = (r == NReads - 1);
        exp_w.push_back(w);
      end
    end

    trigger  = trig;
    post_cnt = post;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    trigger  = $urandom;
    post_cnt = 10'($urandom);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("err_cleared_by_start", {31'b0, err_o}, 32'd0);

    for (int i = 0; i < 40000 && done_cnt == d0; i++) begin
      if (poke && poke_st == 0 && txn_q.size() >= 4) begin
        start = 1'b1; trigger = ~trig; post_cnt = ~post; poke_st = 1;
      end else if (poke_st == 1) begin
        start = 1'b0; poke_st = 2;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);

    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("err_flag", {31'b0, err_o}, {31'b0, exp_err});
    check("out_valid_after_done", {31'b0, out_valid}, 32'd0);
    check("txn_count", 32'(txn_q.size()), 32'(exp_t.size()));
    for (int i = 0; i < exp_t.size() && i < txn_q.size(); i++) begin
      check($sformatf("txn%0d_adr", i), txn_q[i].adr, exp_t[i].adr);
      check($sformatf("txn%0d_we", i), {31'b0, txn_q[i].we}, {31'b0, exp_t[i].we});
      check($sformatf("txn%0d_dat", i), txn_q[i].dat, exp_t[i].dat);
    end
    check("word_count", 32'(out_q.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < out_q.size(); i++) begin
      check($sformatf("word%0d_data", i), out_q[i].data, exp_w[i].data);
      check($sformatf("word%0d_last", i), {31'b0, out_q[i].last}, {31'b0, exp_w[i].last});
    end
    if (etx < 0 || etx > 2) begin
      check("wait_window", {31'b0, (first_rd_cyc - arm_ack_cyc >= WaitCyc) &&
                                   (first_rd_cyc - arm_ack_cyc <= WaitCyc + 3)}, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adr"}, wbm_adr, 32'h0);
    check({tag, "_dat"}, wbm_dat_o, 32'h0);
    check({tag, "_sel"}, {28'b0, wbm_sel}, 32'hf);
    check({tag, "_we"}, {31'b0, wbm_we}, 32'd0);
    check({tag, "_cyc"}, {31'b0, wbm_cyc}, 32'd0);
    check({tag, "_stb"}, {31'b0, wbm_stb}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_err"}, {31'b0, err_o}, 32'd0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_last"}, {31'b0, out_last}, 32'd0);
    check({tag, "_data"}, out_data, 32'h0);
  endtask

  typedef struct {
    logic [31:0] trig;
    logic [9:0]  post;
    int          etx;      // transaction index that gets a bus error, -1 for none
    int          stall_w;  // stream index held off for 50 cycles, -1 for none
    int          rdy;      // sink ready probability in percent
    bit          poke;     // pulse start again while reading
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_0055, 10'd10,   -1,          7, 80,  1'b0, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 10'd1023, -1,         -1, 40,  1'b0, 1'b0};
    vecs[2] = '{32'h0000_0001, 10'd0,    2 + NWords + 2, -1, 90, 1'b0, 1'b1};
    vecs[3] = '{32'hCAFE_F00D, 10'd512,  -1,         -1, 100, 1'b1, 1'b0};
    vecs[4] = '{32'h1234_5678, 10'd5,    0,          -1, 100, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 10'd1,    1,          -1, 100, 1'b0, 1'b1};
    vecs[6] = '{$urandom, 10'($urandom), 2 + NReads - 1, -1, 60, 1'b0, 1'b1};
    vecs[7] = '{$urandom, 10'($urandom), -1,         -1, 70,  1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_seq(vecs[v].trig, vecs[v].post, vecs[v].etx, vecs[v].stall_w, vecs[v].rdy,
              vecs[v].poke, vecs[v].exp_err);
    end

    // Leave err_o set, then reset asynchronously in the middle of the wait window.
    run_seq(32'h0BAD_0BAD, 10'd3, 1, -1, 100, 1'b0, 1'b1);
    txn_q.delete();
    err_txn = -1;
    trigger = 32'h0000_00AA; post_cnt = 10'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && txn_q.size() < 2; i++) @(negedge clk);
    check("reached_wait", 32'(txn_q.size()), 32'd2);
    repeat (5) @(negedge clk);
    check("busy_in_wait", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_seq(32'h0000_0055, 10'd10, -1, -1, 85, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tracer_reader.md
Name: tracer_reader

Overview:
- Wishbone initiator that drives the trace logger from the master side.
- On start it programs the post-trigger count, arms the trigger, waits a fixed capture window, then reads back all four trace banks word by word.
- Each word read is forwarded on a valid/ready output stream, typically to a UART or JTAG bridge.
- Sits between the host-debug transport and the trace logger's Wishbone slave port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the trace logger slave.
- NUM_WORDS, 1024, words read per bank; power of two, max 1024.
- NUM_BANKS, 4, banks read; bank b is at BASE_ADDR + b*32'h1000.
- WAIT_CYCLES, 2048, clocks between the arm-write ack and the first read; must be at least 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbm_adr_o  out  32  byte address
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects, always 4'hf
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error
- start_i  in  1  one-cycle start pulse
- trigger_i  in  32  trigger pattern, sampled at start
- post_cnt_i  in  10  post-trigger sample count, sampled at start
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at sequence end
- err_o  out  1  sticky bus error, cleared by next accepted start
- out_data_o  out  32  trace word
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  sink ready
- out_last_o  out  1  marks the final word of the whole dump

Behaviour:
- Reset (async assert, sync deassert use): FSM=IDLE.
  - All Wishbone outputs 0 except wbm_sel_o=4'hf.
  - busy_o, done_o, err_o, out_valid_o, out_last_o = 0; out_data_o = 0.
- FSM states: IDLE, WR_POST, WR_ARM, WAIT, RD, OUT, FIN.
- IDLE:
  - start_i=1 latches trigger_i and post_cnt_i, clears err_o, sets busy_o, goes to WR_POST.
  - start_i while busy_o=1 is ignored.
- WR_POST: write {22'b0, post_cnt} to BASE_ADDR+32'h10, on ack go to WR_ARM.
- WR_ARM: write trigger to BASE_ADDR+32'h0, on ack go to WAIT. Post count is always written before arm.
- WAIT: counter runs WAIT_CYCLES clocks, then bank=0, word=0, go to RD.
- RD: read BASE_ADDR + bank*32'h1000 + word*4. On ack capture wbm_dat_i into out_data_o, set out_valid_o, go to OUT.
- OUT:
  - Hold out_data_o and out_valid_o stable until out_ready_i=1.
  - On the transfer, increment word; on word wrap increment bank.
  - Return to RD, or go to FIN after bank NUM_BANKS-1, word NUM_WORDS-1.
  - out_last_o=1 only with that final word.
- FIN: done_o=1 for one cycle, busy_o=0, go to IDLE.
- Bus cycle rules:
  - cyc and stb assert together and hold with address/data/we stable until ack or err.
  - Both drop the cycle after ack; min one idle cycle between transactions.
  - No pipelining; no timeout.
- wbm_err_i in any bus state: drop cyc/stb, set err_o, go to FIN. No output word is produced for that access.
- Backpressure: out_ready_i low indefinitely stalls in OUT with no bus activity.
- Reset mid-sequence: immediate abort to IDLE; the stream may lose an in-flight word.
- Counters: word is log2(NUM_WORDS) bits; bank is 2 bits; WAIT counter is 32 bits.

Optional Feature:
- TRACER_READER_HEADER_EN defined: before the first word of each bank, emit a header word 32'hDA7A_0000 | bank on the stream (same handshake, out_last_o=0).
  - Stream length becomes NUM_BANKS*(NUM_WORDS+1).
- Undefined: no header words; stream is NUM_BANKS*NUM_WORDS words.

Test Plan:
1. Start with trigger_i=32'h55, post_cnt_i=10, slave model acks in 1 cycle -> write 0x0A to 0x10, then write 0x55 to 0x0; after WAIT_CYCLES, first read at 0x0000, last read at 0x3FFC; 4096 words out, out_last_o only on the last; single done_o pulse.
2. Sink holds out_ready_i=0 for 50 cycles on word 7 -> out_data_o stable and cyc=0 throughout; word 8 is read only after the handshake.
3. Slave returns err on read at 0x1008 -> cyc/stb drop the next cycle, err_o=1, done_o pulses, no word emitted for 0x1008; the next start clears err_o.
4. start_i pulsed during RD -> ignored, no address or count change; start after done_o is accepted.
5. Reset asserted asynchronously mid-WAIT -> outputs reach reset values without a clock edge; a fresh start then runs a full sequence.
6. With TRACER_READER_HEADER_EN, NUM_WORDS=4 -> stream is DA7A0000, w0..w3, DA7A0001, ...; 20 words total, last has out_last_o=1.
